// File: rtl/core_dbg_apb_arb.sv
// Two-requester APB master for the core debug bus: round-robin grant, SETUP/ACCESS
// sequencing, read-data return and timeout abort of transfers whose ready never arrives.
module core_dbg_apb_arb #(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      a_req,
  input  logic [APB_ADDR_WIDTH-1:0] a_addr,
  input  logic                      a_wr,
  input  logic [APB_DATA_WIDTH-1:0] a_wdata,
  input  logic [3:0]                a_wstrb,
  output logic                      a_done,
  output logic                      a_err,
  output logic [APB_DATA_WIDTH-1:0] a_rdata,
  input  logic                      b_req,
  input  logic [APB_ADDR_WIDTH-1:0] b_addr,
  input  logic                      b_wr,
  input  logic [APB_DATA_WIDTH-1:0] b_wdata,
  input  logic [3:0]                b_wstrb,
  output logic                      b_done,
  output logic                      b_err,
  output logic [APB_DATA_WIDTH-1:0] b_rdata,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  output logic [3:0]                pstrb,
  input  logic                      pready,
  input  logic [APB_DATA_WIDTH-1:0] prdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_t;

  state_t           state_q, state_d;
  logic             grant_q;       // 1 = B owns the current transfer
  logic             last_grant_q;  // 1 = B was served last
  logic [CNT_W-1:0] cnt_q;
  logic             pick_b;
  logic             timeout_hit;

  // On a tie, B wins only if A was served last.
  assign pick_b      = b_req && (!a_req || !last_grant_q);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES));

  assign psel    = (state_q == StSetup) || (state_q == StAccess);
  assign penable = (state_q == StAccess);
  assign a_done  = (state_q == StDone) && !grant_q;
  assign b_done  = (state_q == StDone) && grant_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (a_req || b_req) state_d = StSetup;
      StSetup:  state_d = StAccess;
      StAccess: if (pready || timeout_hit) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      paddr        <= '0;
      pwrite       <= 1'b0;
      pwdata       <= '0;
      pstrb        <= '0;
      a_err        <= 1'b0;
      b_err        <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (a_req || b_req) begin
            grant_q <= pick_b;
            cnt_q   <= '0;
            paddr   <= pick_b ? b_addr : a_addr;
            pwrite  <= pick_b ? b_wr : a_wr;
            pwdata  <= pick_b ? b_wdata : a_wdata;
            if (pick_b) pstrb <= b_wr ? b_wstrb : 4'b0000;
            else        pstrb <= a_wr ? a_wstrb : 4'b0000;
          end
        end
        StAccess: begin
          if (pready) begin
            if (grant_q) begin
              b_err <= 1'b0;
              if (!pwrite) b_rdata <= prdata;
            end else begin
              a_err <= 1'b0;
              if (!pwrite) a_rdata <= prdata;
            end
          end else if (timeout_hit) begin
            if (grant_q) begin
              b_err   <= 1'b1;
              b_rdata <= '0;
            end else begin
              a_err   <= 1'b1;
              a_rdata <= '0;
            end
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: last_grant_q <= grant_q;
        default: ;
      endcase
    end
  end

endmodule
